// File: rtl/newhope_pkg.sv
// Shared NewHope pipeline definitions: default sizes, stage FSM states, reduction constants.
package newhope_pkg;

  localparam int unsigned Q_DEF      = 12289;
  localparam int unsigned N_DEF      = 512;
  localparam int unsigned COEF_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Entry m of the reduction table: the m-th multiple of the modulus.
  function automatic int unsigned red_const(input int unsigned q, input int unsigned m);
    return q * m;
  endfunction

endpackage

// File: rtl/pl_stage_madd_if.sv
// Load/control/output bundle of the modular add/subtract stage.
interface pl_stage_madd_if #(
  parameter int unsigned N        = newhope_pkg::N_DEF,
  parameter int unsigned COEF_W   = newhope_pkg::COEF_W_DEF,
  parameter int unsigned CHANNELS = 3
);

  localparam int unsigned ADDR_W = $clog2(N);

  logic                         en;
  logic                         start_stage;
  logic                         done_stage;
  logic                         busy;
  logic [CHANNELS-1:0]          sub_mask;
  logic [CHANNELS-1:0]          we_in;
  logic [CHANNELS*ADDR_W-1:0]   addr_in;
  logic [CHANNELS*COEF_W-1:0]   din_in;
  logic                         we_r;
  logic [ADDR_W-1:0]            addr_r;
  logic [COEF_W-1:0]            dout_r;

  // Driver side: upstream loader / sequencer.
  modport master (
    output en, start_stage, sub_mask, we_in, addr_in, din_in,
    input  done_stage, busy, we_r, addr_r, dout_r
  );

  // Stage side.
  modport slave (
    input  en, start_stage, sub_mask, we_in, addr_in, din_in,
    output done_stage, busy, we_r, addr_r, dout_r
  );

endinterface

// File: rtl/pl_coef_ram.sv
// One polynomial buffer: N x COEF_W, single write port, registered read port.
module pl_coef_ram #(
  parameter int unsigned N      = 512,
  parameter int unsigned COEF_W = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(N)-1:0]     waddr_i,
  input  logic [COEF_W-1:0]        wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(N)-1:0]     raddr_i,
  output logic [COEF_W-1:0]        rdata_o
);

  logic [COEF_W-1:0] mem_q [N];
  logic [COEF_W-1:0] rdata_q;

  // Storage and read register carry no reset so contents survive rst between passes.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pl_stage_madd.sv
// Multi-channel modular add/subtract stage: buffers CHANNELS polynomials, then streams
// sum_k (+/-) a_k[i] mod Q for i = 0..N-1, one coefficient per enabled cycle.
module pl_stage_madd
  import newhope_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned COEF_W   = COEF_W_DEF,
  parameter int unsigned Q        = Q_DEF,
  parameter int unsigned CHANNELS = 3
) (
  input  logic            clk,
  input  logic            rst,
  pl_stage_madd_if.slave  bus
);

  localparam int unsigned ADDR_W = $clog2(N);
  localparam int unsigned SUM_W  = COEF_W + $clog2(CHANNELS);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CHANNELS-1:0] sub_q, sub_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept_c, issue_c, load_ok_c;

  // vld_q[0]: RAM read data valid, vld_q[1]: P2 valid, vld_q[2]: P3 output valid.
  logic [2:0]          vld_q;

  logic [ADDR_W-1:0]   addr_p1_q, addr_p2_q, addr_r_q;
  logic [COEF_W-1:0]   rdata_c [CHANNELS];
  logic [COEF_W-1:0]   norm_c  [CHANNELS];
  logic [COEF_W-1:0]   p2_c    [CHANNELS];
  logic [COEF_W-1:0]   p2_q    [CHANNELS];
  logic [SUM_W-1:0]    sum_c, sel_c;
  logic [COEF_W-1:0]   dout_c, dout_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; everything freezes while en is low.
  always_comb begin
    state_d = state_q;
    if (bus.en) begin
      case (state_q)
        IDLE:    if (bus.start_stage) state_d = RUN;
        RUN:     if (rd_cnt_q == ADDR_W'(N - 1)) state_d = DRAIN;
        DRAIN:   if (vld_q[1:0] == 2'b00) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: start acceptance, address issue, counter/sub_mask update, status next values.
  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    sub_d     = sub_q;
    accept_c  = bus.en && (state_q == IDLE) && bus.start_stage;
    issue_c   = bus.en && (state_q == RUN);
    load_ok_c = (state_q == IDLE);
    if (accept_c) begin
      sub_d    = bus.sub_mask;
      rd_cnt_d = '0;
    end
    if (issue_c) begin
      rd_cnt_d = (rd_cnt_q == ADDR_W'(N - 1)) ? '0 : rd_cnt_q + ADDR_W'(1);
    end
    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // Control registers and the pipeline valid shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      sub_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      vld_q    <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      sub_q    <= sub_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      if (bus.en) begin
        vld_q <= {vld_q[1:0], issue_c};
      end
    end
  end

  // Per-channel buffers; loads are only honoured while idle.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ram
    pl_coef_ram #(
      .N      (N),
      .COEF_W (COEF_W)
    ) u_ram (
      .clk     (clk),
      .we_i    (bus.we_in[k] && load_ok_c),
      .waddr_i (bus.addr_in[k*ADDR_W +: ADDR_W]),
      .wdata_i (bus.din_in[k*COEF_W +: COEF_W]),
      .re_i    (bus.en),
      .raddr_i (rd_cnt_q),
      .rdata_o (rdata_c[k])
    );
  end

  // P2: fold [0,2Q-1] into [0,Q-1], then negate mod Q for subtracted channels (0 stays 0).
  always_comb begin
    for (int k = 0; k < int'(CHANNELS); k++) begin
      norm_c[k] = (rdata_c[k] >= COEF_W'(Q)) ? rdata_c[k] - COEF_W'(Q) : rdata_c[k];
      if (sub_q[k] && (norm_c[k] != '0)) begin
        p2_c[k] = COEF_W'(Q) - norm_c[k];
      end else begin
        p2_c[k] = norm_c[k];
      end
    end
  end

  // P3: wide sum, then subtract the largest multiple of Q not exceeding it.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      sum_c = sum_c + SUM_W'(p2_q[k]);
    end
    sel_c = '0;
    for (int unsigned m = 1; m < CHANNELS; m++) begin
      if (sum_c >= SUM_W'(red_const(Q, m))) begin
        sel_c = SUM_W'(red_const(Q, m));
      end
    end
    dout_c = COEF_W'(sum_c - sel_c);
  end

  // Datapath pipeline registers, advancing only on enabled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(CHANNELS); k++) begin
        p2_q[k] <= '0;
      end
      addr_p1_q <= '0;
      addr_p2_q <= '0;
      addr_r_q  <= '0;
      dout_q    <= '0;
    end else if (bus.en) begin
      for (int k = 0; k < int'(CHANNELS); k++) begin
        p2_q[k] <= p2_c[k];
      end
      addr_p1_q <= rd_cnt_q;
      addr_p2_q <= addr_p1_q;
      addr_r_q  <= addr_p2_q;
      dout_q    <= dout_c;
    end
  end

  // Strobes are masked by en in the same cycle so a held output is emitted exactly once.
  assign bus.we_r       = vld_q[2] & bus.en;
  assign bus.done_stage = done_q & bus.en;
  assign bus.busy       = busy_q;
  assign bus.addr_r     = addr_r_q;
  assign bus.dout_r     = dout_q;

endmodule

// File: tb/tb_pl_stage_madd.sv
// Randomised scoreboard bench for pl_stage_madd with a plain-arithmetic mod-Q reference.
module tb_pl_stage_madd;
  import newhope_pkg::*;

  localparam int unsigned N      = 512;
  localparam int unsigned CH     = 3;
  localparam int unsigned COEF_W = 16;
  localparam int unsigned Q      = 12289;
  localparam int unsigned AW     = $clog2(N);

  typedef struct {
    int addr;
    int data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pl_stage_madd_if #(.N(N), .COEF_W(COEF_W), .CHANNELS(CH)) bus ();

  pl_stage_madd #(.N(N), .COEF_W(COEF_W), .Q(Q), .CHANNELS(CH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   mem [CH][N];
  int   checks     = 0;
  int   failures   = 0;
  int   n_out      = 0;
  int   done_cnt   = 0;
  int   cyc        = 0;
  int   stall_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // en driver: 0 = always on, 1 = low every third cycle, 2 = random ~25% low.
  initial begin
    bus.en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (stall_mode)
        1:       bus.en = (cyc % 3 != 0);
        2:       bus.en = ($urandom_range(0, 3) != 0);
        default: bus.en = 1'b1;
      endcase
    end
  end

  // Monitor: every presented output is popped from the scoreboard and compared.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done_stage) done_cnt++;
    if (bus.we_r) begin
      checks++;
      if (!bus.en) begin
        failures++;
        $display("FAIL we_during_stall addr=%0d", bus.addr_r);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual addr=%0d data=%0d required no write", bus.addr_r, bus.dout_r);
      end else begin
        e = exp_q.pop_front();
        n_out++;
        if (int'(bus.addr_r) != e.addr || int'(bus.dout_r) != e.data) begin
          failures++;
          $display("FAIL out_coef actual addr=%0d data=%0d required addr=%0d data=%0d",
                   bus.addr_r, bus.dout_r, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: each channel reduced mod Q, negated mod Q when subtracted, summed mod Q.
  function automatic int model(input int i, input logic [CH-1:0] sub);
    int q = int'(Q);
    int s = 0;
    int v;
    for (int k = 0; k < int'(CH); k++) begin
      v = mem[k][i] % q;
      if (sub[k]) v = (q - v) % q;
      s += v;
    end
    return s % q;
  endfunction

  function automatic int gen(input int mode, input int k, input int i);
    int q = int'(Q);
    case (mode)
      0: return q - 1;
      1: return i;
      2: return 0;
      4: return (k == 0) ? q + 5 : 0;
      5: return (k < 2) ? i : 0;
      default: begin
        case ($urandom_range(0, 5))
          0:       return 0;
          1:       return q - 1;
          2:       return q;
          3:       return q + 5;
          4:       return 2 * q - 1;
          default: return int'($urandom_range(0, 2 * Q - 1));
        endcase
      end
    endcase
  endfunction

  // Write every address of the masked channels and mirror it into the model.
  task automatic load(input logic [CH-1:0] mask, input int mode);
    logic [CH*AW-1:0]     a;
    logic [CH*COEF_W-1:0] d;
    int                   val;
    for (int i = 0; i < int'(N); i++) begin
      @(posedge clk);
      #2;
      for (int k = 0; k < int'(CH); k++) begin
        val = gen(mode, k, i);
        a[k*AW +: AW]         = AW'(i);
        d[k*COEF_W +: COEF_W] = COEF_W'(val);
        if (mask[k]) mem[k][i] = val;
      end
      bus.we_in   = mask;
      bus.addr_in = a;
      bus.din_in  = d;
    end
    @(posedge clk);
    #2;
    bus.we_in = '0;
  endtask

  task automatic run_pass(input logic [CH-1:0] sub, input bit timing, input bit disturb, input int rst_at);
    int t      = 0;
    int encnt  = 0;
    bit got    = 0;
    int base;
    int d0;
    @(posedge clk);
    #2;
    while (!bus.en) begin
      @(posedge clk);
      #2;
    end
    bus.sub_mask    = sub;
    bus.start_stage = 1'b1;
    for (int i = 0; i < int'(N); i++) exp_q.push_back('{addr: i, data: model(i, sub)});
    base = n_out;
    while (!got && t < 4 * int'(N)) begin
      @(negedge clk);
      if (bus.en) encnt++;
      if (timing && t == 1) chk("busy_cycle1", int'(bus.busy), 1);
      if (timing && t == 3) chk("no_we_cycle3", int'(bus.we_r), 0);
      if (timing && t == 4) begin
        chk("we_cycle4", int'(bus.we_r), 1);
        chk("addr_cycle4", int'(bus.addr_r), 0);
      end
      if (bus.done_stage) begin
        got = 1;
        chk("done_en_cycles", encnt, int'(N) + 5);
        chk("busy_at_done", int'(bus.busy), 0);
        chk("queue_drained", exp_q.size(), 0);
      end else begin
        @(posedge clk);
        #2;
        bus.start_stage = 1'b0;
        bus.we_in       = '0;
        t++;
        if (disturb && t == 200) bus.start_stage = 1'b1;
        if (disturb && t >= 300 && t < 304) begin
          bus.we_in   = '1;
          bus.addr_in = (CH*AW)'($urandom());
          bus.din_in  = (CH*COEF_W)'({$urandom(), $urandom()});
        end
        if (rst_at >= 0 && n_out - base >= rst_at) begin
          rst = 1'b1;
          @(posedge clk);
          #2;
          rst = 1'b0;
          exp_q.delete();
          @(negedge clk);
          chk("rst_we_r", int'(bus.we_r), 0);
          chk("rst_busy", int'(bus.busy), 0);
          chk("rst_done", int'(bus.done_stage), 0);
          chk("rst_dout", int'(bus.dout_r), 0);
          d0 = done_cnt;
          repeat (N + 10) @(posedge clk);
          chk("no_done_after_rst", done_cnt - d0, 0);
          return;
        end
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no done_stage required=done_stage within %0d cycles", 4 * N);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.start_stage = 1'b0;
    bus.sub_mask    = '0;
    bus.we_in       = '0;
    bus.addr_in     = '0;
    bus.din_in      = '0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_done", int'(bus.done_stage), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_we_r", int'(bus.we_r), 0);
    chk("reset_addr_r", int'(bus.addr_r), 0);
    chk("reset_dout_r", int'(bus.dout_r), 0);

    // All coefficients Q-1 added: 3*(Q-1) mod Q = Q-3.
    load(3'b111, 0);
    run_pass(3'b000, 1'b1, 1'b0, -1);

    // a - a = 0, then a + 0 = a.
    load(3'b111, 5);
    run_pass(3'b010, 1'b0, 1'b0, -1);
    load(3'b010, 2);
    run_pass(3'b000, 1'b0, 1'b0, -1);

    // Q+5 folds to 5; negating zero stays zero.
    load(3'b111, 4);
    run_pass(3'b000, 1'b0, 1'b0, -1);
    run_pass(3'b111, 1'b0, 1'b0, -1);

    // Corner-heavy random data under several sub masks and stall patterns.
    load(3'b111, 3);
    run_pass(CH'($urandom()), 1'b0, 1'b0, -1);
    stall_mode = 1;
    run_pass(CH'($urandom()), 1'b0, 1'b0, -1);
    stall_mode = 2;
    run_pass(CH'($urandom()), 1'b0, 1'b0, -1);

    // Abandoned pass, then a full pass from retained RAM.
    stall_mode = 0;
    run_pass(3'b101, 1'b0, 1'b0, 100);
    run_pass(3'b101, 1'b1, 1'b0, -1);

    // Restart attempts and loads while busy must not disturb the pass.
    stall_mode = 2;
    run_pass(CH'($urandom()), 1'b0, 1'b1, -1);
    stall_mode = 0;
    run_pass(3'b011, 1'b0, 1'b0, -1);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
